// File: rtl/cnt_seq_checker.sv
// Receive-side checker for an incrementing DW-bit counter stream.
// Acquires lock on LOCK_LEN in-sequence samples, then flags and counts mismatches.
module cnt_seq_checker #(
   parameter int DW          = 8,
   parameter int ERR_W       = 16,
   parameter int LOCK_LEN    = 4,
   parameter int UNLOCK_ERRS = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             din_valid,
   input  logic [DW-1:0]    din,
   input  logic             clr,
   output logic             locked,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt,
   output logic [ERR_W-1:0] wrap_cnt,
   output logic [DW-1:0]    exp_data
);

   // state | meaning
   // IDLE  | checker disabled, din ignored
   // SEEK  | looking for LOCK_LEN consecutive in-sequence samples
   // CHECK | locked, every valid sample compared against exp_data
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEEK  = 2'd1,
      CHECK = 2'd2
   } state_t;

   localparam int GW = $clog2(LOCK_LEN + 1);
   localparam int BW = $clog2(UNLOCK_ERRS + 1);
   localparam logic [GW-1:0]    LOCK_CNT   = GW'(LOCK_LEN);
   localparam logic [BW-1:0]    UNLOCK_CNT = BW'(UNLOCK_ERRS);
   localparam logic [DW-1:0]    ONE_D      = DW'(1);
   localparam logic [GW-1:0]    ONE_G      = GW'(1);
   localparam logic [BW-1:0]    ONE_B      = BW'(1);
   localparam logic [ERR_W-1:0] ONE_E      = ERR_W'(1);

   state_t             state_q, state_d;
   logic [DW-1:0]      prev_q, prev_d;
   logic [GW-1:0]      good_q, good_d;
   logic [BW-1:0]      bad_q, bad_d;
   logic [DW-1:0]      exp_q, exp_d;
   logic               err_q, err_d;
   logic [ERR_W-1:0]   ecnt_q, ecnt_d;
   logic [ERR_W-1:0]   wcnt_q, wcnt_d;
   logic [DW-1:0]      prev_inc;
   logic [DW-1:0]      din_inc;
   logic [DW-1:0]      exp_inc;

   assign prev_inc = prev_q + ONE_D;
   assign din_inc  = din + ONE_D;
   assign exp_inc  = exp_q + ONE_D;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         prev_q  <= '0;
         good_q  <= '0;
         bad_q   <= '0;
         exp_q   <= '0;
         err_q   <= 1'b0;
         ecnt_q  <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
         exp_q   <= exp_d;
         err_q   <= err_d;
         ecnt_q  <= ecnt_d;
         wcnt_q  <= wcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      good_d  = good_q;
      bad_d   = bad_q;
      exp_d   = exp_q;
      err_d   = 1'b0;
      ecnt_d  = ecnt_q;
      wcnt_d  = wcnt_q;

      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = SEEK;
               good_d  = '0;
            end
            SEEK: begin
               if (din_valid) begin
                  prev_d = din;
                  if ((good_q != '0) && (din == prev_inc)) good_d = good_q + ONE_G;
                  else                                     good_d = ONE_G;
                  if (good_d == LOCK_CNT) begin
                     state_d = CHECK;
                     exp_d   = din_inc;
                     bad_d   = '0;
                  end
               end
            end
            CHECK: begin
               if (din_valid) begin
                  if (din == exp_q) begin
                     exp_d = exp_inc;
                     bad_d = '0;
                     if (din == '0) wcnt_d = wcnt_q + ONE_E;
                  end else begin
                     err_d = 1'b1;
                     if (ecnt_q != '1) ecnt_d = ecnt_q + ONE_E;
                     exp_d = din_inc;
                     bad_d = bad_q + ONE_B;
                     // the resynced value seeds SEEK as a run of one
                     if (bad_d == UNLOCK_CNT) begin
                        state_d = SEEK;
                        good_d  = ONE_G;
                        prev_d  = din;
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (clr) begin
         ecnt_d = '0;
         wcnt_d = '0;
      end
   end

   assign locked   = (state_q == CHECK);
   assign err      = err_q;
   assign err_cnt  = ecnt_q;
   assign wrap_cnt = wcnt_q;
   assign exp_data = exp_q;

endmodule
